// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the MEM stage: parameter defaults, FSM state encoding
// and the sizing rule for the access timeout counter.
// No logic of its own; imported by the interface, the MEM/WB register and the top.
package mem_access_stage_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 4;
  localparam int ADDR_WIDTH_DEF     = 8;
  localparam int TIMEOUT_CYCLES_DEF = 15;

  // FSM state encoding, kept as plain constants so older tools and scripts
  // that probe the state register see stable numeric values.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // The counter must be able to hold TIMEOUT_CYCLES itself, hence the +1.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the memory.
// Request side is registered in the stage; rdata is only meaningful while ack is high.
// ack is a single-cycle completion pulse; the stage holds req until ack or abort.
interface mem_access_stage_if
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  // The pipeline stage issues requests.
  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  // The data memory answers them.
  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );

endinterface

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register: captures write-back data, destination and enable.
// Latency 1 cycle from a load request; a non-load cycle inserts a bubble.
// enable low freezes every field; bubbles clear only the write enable.
module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
  input  logic                      reg_wen_in,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_out,
  output logic                      wb_reg_wen_out
);

  // Retire an instruction on load; otherwise push a bubble (data and rd held
  // so that the write-back bus does not toggle needlessly).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_out    <= '0;
      wb_rd_addr_out <= '0;
      wb_reg_wen_out <= 1'b0;
    end else if (enable) begin
      if (load) begin
        wb_data_out    <= data_in;
        wb_rd_addr_out <= rd_addr_in;
        wb_reg_wen_out <= reg_wen_in;
      end else begin
        wb_reg_wen_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives data memory over req/ack and owns the MEM/WB register.
// Latency 1 cycle for ALU ops, 1+N for memory ops (N = ACCESS cycles up to the ack).
// Stalls upstream via combinational mem_stall; aborts after TIMEOUT_CYCLES without ack.
// Optional build macro MEM_ALIGN_CHECK_EN: reject misaligned memory ops without a request.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
  input  logic                      reg_wen_in,
  input  logic                      mem_wen_in,
  input  logic                      is_mem_inst_in,
  input  logic                      is_load_in,
  mem_access_stage_if.master        dmem,
  output logic                      mem_stall,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_out,
  output logic                      wb_reg_wen_out,
  output logic                      mem_error
);

  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  misaligned;
  logic                  issue;
  logic                  timeout_hit;
  logic                  wb_load;
  logic [DATA_WIDTH-1:0] wb_d_data;
  logic                  wb_d_wen;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |alu_result_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // A memory op in IDLE starts an access unless it is rejected for alignment.
  assign issue = (state == ST_IDLE) && is_mem_inst_in && !misaligned;

  // Last ACCESS cycle without an ack; an ack arriving now takes priority.
  assign timeout_hit = (state == ST_ACCESS) && !dmem.ack && (cnt == CNT_LAST);

  // Hold upstream while a request is being set up or is still outstanding.
  always_comb begin
    mem_stall = 1'b0;
    if (state == ST_IDLE) begin
      mem_stall = issue;
    end else begin
      mem_stall = !dmem.ack && !timeout_hit;
    end
  end

  // Select what, if anything, retires into MEM/WB at the next edge.
  always_comb begin
    wb_load   = 1'b0;
    wb_d_data = alu_result_in;
    wb_d_wen  = reg_wen_in;
    if (state == ST_IDLE) begin
      if (!is_mem_inst_in) begin
        wb_load = 1'b1;
      end else if (misaligned) begin
        wb_load   = 1'b1;
        wb_d_data = '0;
        wb_d_wen  = 1'b0;
      end
    end else if (dmem.ack) begin
      wb_load = 1'b1;
      if (is_load_in) begin
        wb_d_data = dmem.rdata;
      end
    end else if (timeout_hit) begin
      wb_load   = 1'b1;
      wb_d_data = '0;
      wb_d_wen  = 1'b0;
    end
  end

  // Access FSM, timeout counter and registered memory request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
    end else if (enable) begin
      if (state == ST_IDLE) begin
        if (issue) begin
          dmem.req   <= 1'b1;
          dmem.we    <= mem_wen_in;
          dmem.addr  <= alu_result_in[ADDR_WIDTH+1:2];
          dmem.wdata <= store_data_in;
          cnt        <= '0;
          state      <= ST_ACCESS;
        end
      end else begin
        if (dmem.ack || timeout_hit) begin
          dmem.req <= 1'b0;
          dmem.we  <= 1'b0;
          state    <= ST_IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Sticky error flag: set by a timeout abort or a rejected misaligned op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_error <= 1'b0;
    end else if (enable) begin
      if (timeout_hit || ((state == ST_IDLE) && is_mem_inst_in && misaligned)) begin
        mem_error <= 1'b1;
      end
    end
  end

  mem_wb_reg #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_mem_wb_reg (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .load           (wb_load),
    .data_in        (wb_d_data),
    .rd_addr_in     (rd_addr_in),
    .reg_wen_in     (wb_d_wen),
    .wb_data_out    (wb_data_out),
    .wb_rd_addr_out (wb_rd_addr_out),
    .wb_reg_wen_out (wb_reg_wen_out)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed test-plan cases then randomized instructions.
// Each instruction is scored against expectations derived from the stage's rules.
// The bench also plays the data memory, acking after a chosen number of cycles.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int DW     = 32;
  localparam int RW     = 4;
  localparam int AW     = 8;
  localparam int TMO    = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] alu_result_in;
  logic [DW-1:0] store_data_in;
  logic [RW-1:0] rd_addr_in;
  logic          reg_wen_in;
  logic          mem_wen_in;
  logic          is_mem_inst_in;
  logic          is_load_in;
  logic          mem_stall;
  logic [DW-1:0] wb_data_out;
  logic [RW-1:0] wb_rd_addr_out;
  logic          wb_reg_wen_out;
  logic          mem_error;

  int  checks = 0;
  int  errors = 0;
  logic model_err;

  mem_access_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dmem ();

  mem_access_stage #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (RW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .rd_addr_in     (rd_addr_in),
    .reg_wen_in     (reg_wen_in),
    .mem_wen_in     (mem_wen_in),
    .is_mem_inst_in (is_mem_inst_in),
    .is_load_in     (is_load_in),
    .dmem           (dmem),
    .mem_stall      (mem_stall),
    .wb_data_out    (wb_data_out),
    .wb_rd_addr_out (wb_rd_addr_out),
    .wb_reg_wen_out (wb_reg_wen_out),
    .mem_error      (mem_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store. delay: memory acks on that many
  // enabled ACCESS cycles (beyond TMO means never). hold: cycles of enable=0
  // injected at the start of ACCESS. Called and returns at posedge+2.
  task automatic run_instr(input int kind, input logic [31:0] alu, input logic [31:0] sdata,
                           input logic [31:0] rdv, input logic [3:0] rd, input logic wen,
                           input int delay, input int hold);
    logic        is_mem, misal, tmo, first_req, done;
    int          n, exp_cnt, stall_cnt, req_cnt, en_req, holds_left, cyc;
    logic [31:0] exp_data;
    logic        exp_wen;
    is_mem = (kind != 0);
    misal  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = is_mem && (alu[1:0] != 2'b00);
`endif
    tmo     = is_mem && !misal && (delay > TMO);
    n       = (delay > TMO) ? TMO : delay;
    exp_cnt = (is_mem && !misal) ? n + hold : 0;
    if (!is_mem) begin
      exp_data = alu;
      exp_wen  = wen;
    end else if (misal || tmo) begin
      exp_data = 32'h0;
      exp_wen  = 1'b0;
    end else begin
      exp_data = (kind == 1) ? rdv : alu;
      exp_wen  = wen;
    end
    if (misal || tmo) model_err = 1'b1;

    enable         = 1'b1;
    alu_result_in  = alu;
    store_data_in  = sdata;
    rd_addr_in     = rd;
    reg_wen_in     = wen;
    is_mem_inst_in = is_mem;
    is_load_in     = (kind == 1);
    mem_wen_in     = (kind == 2);
    dmem.ack       = 1'($urandom_range(0, 1));
    dmem.rdata     = $urandom;

    stall_cnt = 0; req_cnt = 0; en_req = 0; holds_left = hold; cyc = 0;
    first_req = 1'b1; done = 1'b0;
    while (!done) begin
      #3;
      if (dmem.req) begin
        req_cnt++;
        if (first_req) begin
          first_req = 1'b0;
          check_eq("dmem_addr", 32'(dmem.addr), (alu >> 2) & 32'hFF);
          check_eq("dmem_we", 32'(dmem.we), 32'(kind == 2));
          check_eq("dmem_wdata", dmem.wdata, sdata);
          check_eq("bubble_wen", 32'(wb_reg_wen_out), 32'h0);
        end
      end
      if (mem_stall) stall_cnt++;
      else done = 1'b1;
      cyc++;
      if (!done && cyc > 60) begin
        check_eq("instr_budget", 32'(cyc), 32'(exp_cnt));
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #2;
        if (dmem.req && holds_left > 0) begin
          enable   = 1'b0;
          dmem.ack = 1'b0;
          holds_left--;
        end else begin
          enable = 1'b1;
          if (dmem.req) begin
            en_req++;
            dmem.ack   = (en_req == delay);
            dmem.rdata = dmem.ack ? rdv : $urandom;
          end else begin
            dmem.ack   = 1'($urandom_range(0, 1));
            dmem.rdata = $urandom;
          end
        end
      end
    end

    @(posedge clk); #1;
    check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_cnt));
    check_eq("req_cycles", 32'(req_cnt), 32'(exp_cnt));
    check_eq("wb_data", wb_data_out, exp_data);
    check_eq("wb_wen", 32'(wb_reg_wen_out), 32'(exp_wen));
    if (!tmo && !misal) check_eq("wb_rd", 32'(wb_rd_addr_out), 32'(rd));
    check_eq("mem_error", 32'(mem_error), 32'(model_err));
    check_eq("req_dropped", 32'(dmem.req), 32'h0);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          k;
    reset = 1'b1; enable = 1'b1;
    alu_result_in = '0; store_data_in = '0; rd_addr_in = '0;
    reg_wen_in = 1'b0; mem_wen_in = 1'b0; is_mem_inst_in = 1'b0; is_load_in = 1'b0;
    dmem.ack = 1'b0; dmem.rdata = '0;
    model_err = 1'b0;

    #2;
    check_eq("rst_req", 32'(dmem.req), 32'h0);
    check_eq("rst_we", 32'(dmem.we), 32'h0);
    check_eq("rst_addr", 32'(dmem.addr), 32'h0);
    check_eq("rst_wdata", dmem.wdata, 32'h0);
    check_eq("rst_wb_data", wb_data_out, 32'h0);
    check_eq("rst_wb_rd", 32'(wb_rd_addr_out), 32'h0);
    check_eq("rst_wb_wen", 32'(wb_reg_wen_out), 32'h0);
    check_eq("rst_err", 32'(mem_error), 32'h0);
    check_eq("rst_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Directed cases from the test plan.
    run_instr(0, 32'h0000_0042, 32'h0, 32'h0, 4'd3, 1'b1, 1, 0);
    run_instr(1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 4'd5, 1'b1, 1, 0);
    run_instr(2, 32'h0000_0020, 32'h0000_1234, 32'h0, 4'd0, 1'b0, 3, 0);
    run_instr(1, 32'h0000_0030, 32'h0, 32'hCAFE_0001, 4'd6, 1'b1, TMO, 0);
    run_instr(2, 32'h0000_0044, 32'h0000_5678, 32'h0, 4'd2, 1'b0, 4, 5);
    run_instr(1, 32'h0000_0013, 32'h0, 32'h0BAD_F00D, 4'd9, 1'b1, 2, 0);
    run_instr(1, 32'h0000_0010, 32'h0, 32'h0, 4'd7, 1'b1, 100, 0);
    run_instr(0, 32'h0000_0055, 32'h0, 32'h0, 4'd1, 1'b1, 1, 0);

    // Reset in the middle of an outstanding load.
    alu_result_in = 32'h40; is_mem_inst_in = 1'b1; is_load_in = 1'b1;
    mem_wen_in = 1'b0; reg_wen_in = 1'b1; dmem.ack = 1'b0;
    @(posedge clk); #2;
    check_eq("midrst_req_before", 32'(dmem.req), 32'h1);
    reset = 1'b1; is_mem_inst_in = 1'b0; is_load_in = 1'b0;
    #1;
    model_err = 1'b0;
    check_eq("midrst_req", 32'(dmem.req), 32'h0);
    check_eq("midrst_stall", 32'(mem_stall), 32'h0);
    check_eq("midrst_wen", 32'(wb_reg_wen_out), 32'h0);
    check_eq("midrst_err", 32'(mem_error), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    run_instr(0, 32'h0000_0077, 32'h0, 32'h0, 4'd4, 1'b1, 1, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 2);
      if (k == 0) begin
        a = $urandom;
      end else begin
        a = $urandom & 32'h0000_03FC;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      end
      run_instr(k, a, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 18),
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Drives the data memory through a req/ack handshake and stalls upstream stages while an access is outstanding.
- Contains the MEM/WB pipeline register, so its registered outputs feed the write-back stage directly.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width
- REG_ADDR_WIDTH, 4, register-file address width
- ADDR_WIDTH, 8, data-memory word-address width
- TIMEOUT_CYCLES, 15, maximum ACCESS cycles without ack before abort (≥1)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global pipeline enable; low freezes FSM, counter and MEM/WB register
- alu_result_in  in  DATA_WIDTH  byte address for memory ops; result for ALU ops
- store_data_in  in  DATA_WIDTH  store data
- rd_addr_in  in  REG_ADDR_WIDTH  destination register
- reg_wen_in  in  1  register write enable
- mem_wen_in  in  1  store flag
- is_mem_inst_in  in  1  load or store present
- is_load_in  in  1  load flag
- dmem_req  out  1  access request, registered
- dmem_we  out  1  write strobe, registered
- dmem_addr  out  ADDR_WIDTH  word address, equal to alu_result_in[ADDR_WIDTH+1:2] latched
- dmem_wdata  out  DATA_WIDTH  latched store data
- dmem_rdata  in  DATA_WIDTH  read data, valid while dmem_ack is high
- dmem_ack  in  1  access complete, single-cycle pulse
- mem_stall  out  1  combinational; high means hold EX/MEM and all earlier stages
- wb_data_out  out  DATA_WIDTH  MEM/WB write-back data
- wb_rd_addr_out  out  REG_ADDR_WIDTH  MEM/WB destination register
- wb_reg_wen_out  out  1  MEM/WB write enable
- mem_error  out  1  sticky timeout flag

Behaviour:
- Reset (async): state IDLE; counter 0; dmem_req, dmem_we, wb_reg_wen_out, mem_error all 0; every data output 0.
- Reset during ACCESS drops dmem_req immediately. The memory must tolerate an abandoned request.
- FSM states: IDLE, ACCESS.
- IDLE, is_mem_inst_in=0:
  - mem_stall=0.
  - Next edge: wb_data_out<=alu_result_in, wb_rd_addr_out<=rd_addr_in, wb_reg_wen_out<=reg_wen_in.
  - Latency is 1 cycle.
- IDLE, is_mem_inst_in=1:
  - mem_stall=1.
  - Next edge: latch addr, wdata and dmem_we<=mem_wen_in; dmem_req<=1; counter<=0; state->ACCESS; wb_reg_wen_out<=0 (bubble).
- ACCESS, dmem_ack=0:
  - mem_stall=1; counter increments; wb_reg_wen_out<=0.
  - If the counter reaches TIMEOUT_CYCLES-1 this cycle, the next edge performs the abort:
  - dmem_req<=0; mem_error<=1; state->IDLE; the instruction retires with wb_reg_wen_out<=0 and wb_data_out<=0.
  - mem_stall is 0 in that final cycle.
- ACCESS, dmem_ack=1:
  - mem_stall=0.
  - Next edge: dmem_req<=0, dmem_we<=0, state->IDLE.
  - Load: wb_data_out<=dmem_rdata, wb_reg_wen_out<=reg_wen_in.
  - Store: wb_data_out<=alu_result_in, wb_reg_wen_out<=reg_wen_in (expected 0).
  - Total latency is 1+N cycles, where N≥1 is the number of ACCESS cycles up to and including the ack.
- dmem_ack in IDLE is ignored.
- Ack on the same cycle the counter hits timeout: ack wins, no error.
- enable=0: all state holds, dmem_req keeps its value, and mem_stall is still driven from the current state.
- Back-to-back memory instructions: the next one is seen in IDLE on the cycle after the ack edge, so each pays the IDLE stall cycle.
- Address low bits [1:0] are ignored in base configuration.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined: a memory instruction in IDLE with alu_result_in[1:0]!=0 issues no request. Next edge: mem_error<=1; instruction retires with wb_reg_wen_out<=0; mem_stall=0 that cycle.
- When undefined: no check is made; bits [1:0] are dropped.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, ACCESS=1)
  - defaults for DATA_WIDTH, REG_ADDR_WIDTH, ADDR_WIDTH
  - width of the timeout counter, $clog2(TIMEOUT_CYCLES+1)
- One sub-module is natural: mem_wb_reg, a plain enable/bubble register for the wb_* outputs. The FSM and handshake stay at top level.

Test Plan:
- ADD result 0x0000_0042, rd=3, reg_wen=1, no mem -> next cycle wb_data_out=0x42, wb_rd_addr_out=3, wb_reg_wen_out=1; mem_stall never high.
- Load from addr 0x10, memory acks on first ACCESS cycle with 0xDEADBEEF:
  - dmem_addr=0x04, dmem_req high for 1 cycle, mem_stall high 1 cycle.
  - wb_data_out=0xDEADBEEF, wb_reg_wen_out=1.
- Store of 0x1234 to 0x20, ack after 3 ACCESS cycles -> dmem_we=1, dmem_wdata=0x1234, dmem_addr=0x08, mem_stall high 3 cycles, wb_reg_wen_out=0.
- Load with no ack, TIMEOUT_CYCLES=15 -> dmem_req high exactly 15 cycles, then mem_error=1 (sticky), wb_reg_wen_out=0, pipeline resumes.
- Reset asserted mid-ACCESS -> dmem_req, mem_stall and wb_reg_wen_out go 0 asynchronously; after release, a non-mem instruction passes in 1 cycle.
- With MEM_ALIGN_CHECK_EN, load from 0x13 -> no dmem_req, mem_error=1, wb_reg_wen_out=0; without the macro -> dmem_addr=0x04 and a normal access occurs.
